frame_dump_seq: RTL and testbench
=================================

# frame_dump_seq

Parametrised frame-dump sequencer for the CSI-2 debug path. It walks a COLS×ROWS grid of downsampled pixel words held in a synchronous-read buffer and serialises each word into bytes. Those bytes go to the UART transmitter through a write/busy handshake, with a programmable idle holdoff between bytes. Compared with the fixed 40×30×4 dump loop, this block adds:
- generic grid and word size;
- selectable byte order;
- triggered or free-running mode;
- correct one-cycle read-latency handling;
- an optional per-frame sync header.

## Interface
- COLS, 40, words per row (≥2)
- ROWS, 30, rows per frame (≥2)
- WORD_BYTES, 4, bytes per buffer word (1..8)
- HOLDOFF, 8191, idle cycles required after UART not busy before next write (≥1)
- MSB_FIRST, 1, 1: byte [8*WORD_BYTES-1 -: 8] sent first; 0: byte [7:0] first
- CONTINUOUS, 1, 1: restart frame automatically; 0: wait for start_i
- sys_clk_i  in  1  system clock (12 MHz domain)
- sys_rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- start_i  in  1  frame trigger, sampled only in IDLE when CONTINUOUS=0
- rd_x_o  out  $clog2(COLS)  buffer column address, registered
- rd_y_o  out  $clog2(ROWS)  buffer row address, registered
- rd_data_i  in  8*WORD_BYTES  buffer read data, valid one cycle after address
- uart_busy_i  in  1  UART transmitting
- uart_wr_o  out  1  one-cycle byte write strobe
- uart_dat_o  out  8  byte, valid with uart_wr_o, held until next write
- busy_o  out  1  high in any state except IDLE
- frame_done_o  out  1  one-cycle pulse after last byte of frame written

## Operation
- Reset values: all outputs 0; state IDLE; holdoff counter 0; frame counter 0.
- States: IDLE, HDR (FRAME_HDR_EN only), FETCH, LATCH, SEND, NEXT.
- IDLE:
  - Go when CONTINUOUS=1, or when CONTINUOUS=0 and start_i=1.
  - On go: rd_x_o=0, rd_y_o=0, then to HDR if enabled, else FETCH.
- FETCH: one wait cycle (buffer registers the address) → LATCH.
- LATCH: capture rd_data_i into the shift register; byte index=0 → SEND.
- SEND:
  - Write condition: holdoff==HOLDOFF && !uart_busy_i && !uart_wr_o.
  - When the condition holds: pulse uart_wr_o, drive the current byte onto uart_dat_o, index+1.
  - After the write of index WORD_BYTES-1 → NEXT.
- NEXT:
  - rd_x_o<COLS-1: rd_x_o+1 → FETCH.
  - Otherwise rd_x_o=0. If rd_y_o<ROWS-1: rd_y_o+1 → FETCH.
  - Otherwise: pulse frame_done_o, frame counter+1 (8-bit, wraps 255→0), addresses 0 → IDLE.
- Holdoff counter:
  - Width $clog2(HOLDOFF+1).
  - Cleared in any cycle where uart_busy_i=1 or uart_wr_o=1.
  - Otherwise increments, saturating at HOLDOFF.
  - Runs in every state, so the first byte of a frame may go immediately if the line is already idle.
- start_i outside IDLE is ignored. When start_i and frame end coincide, the new frame is not started; a fresh start_i in IDLE is required.
- Reset mid-frame: asynchronous return to reset values. A pending uart_wr_o is dropped the same instant. The next frame begins at (0,0).

## Timing
- Address to capture: rd_x_o/rd_y_o change on the NEXT→FETCH edge; rd_data_i is sampled at the end of the LATCH cycle.
- Minimum byte spacing: uart_wr_o, then clear, then HOLDOFF increments plus any busy time. A UART that never asserts busy gives exactly HOLDOFF+1 cycles between strobes.
- Per word, with UART always idle:
  - SEND holds WORD_BYTES write cycles and the holdoff waits between them.
  - Add 3 cycles of overhead: NEXT, FETCH, LATCH.
- CONTINUOUS=1: IDLE lasts exactly one cycle after frame_done_o.
- frame_done_o is asserted in the cycle after the final uart_wr_o.

## Configuration
- FRAME_HDR_EN defined:
  - HDR state sends 4 bytes before the first word: 0xA5, 0x5A, frame_cnt, ~frame_cnt.
  - Header bytes obey the same holdoff/busy rules.
  - HDR → FETCH after the 4th write.
- FRAME_HDR_EN undefined: HDR state and frame counter are not built; IDLE → FETCH directly. Total bytes per frame = COLS·ROWS·WORD_BYTES.

## Test plan
- COLS=3, ROWS=2, WORD_BYTES=2, MSB_FIRST=1, HOLDOFF=3, buffer word = {y,x} → bytes 00 00, 00 01, 00 02, 01 00, 01 01, 01 02 in order, then one frame_done_o pulse.
- MSB_FIRST=0, word 0xBEEF at (0,0) → first byte EF, second BE.
- uart_busy_i held high 10 cycles after each strobe → next strobe exactly 4 cycles after busy falls; no strobe while busy.
- CONTINUOUS=0: start_i pulse → one frame, back to IDLE with busy_o=0. start_i pulsed mid-frame → no effect on byte count (12).
- sys_rst_i asserted during 2nd byte of word (1,1) → uart_wr_o, busy_o, rd_x_o, rd_y_o all 0 immediately. After release, the first bytes come from (0,0).
- FRAME_HDR_EN defined, CONTINUOUS=1, two frames → headers A5 5A 00 FF, then A5 5A 01 FE.

Source files
------------

// File: rtl/frame_dump_seq.sv
// Frame-dump sequencer: walks a COLS x ROWS word buffer and serialises each word to a UART byte stream.
// Define FRAME_HDR_EN to prepend a 4-byte sync header (A5 5A cnt ~cnt) to every frame.
module frame_dump_seq #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int WORD_BYTES = 4,
    parameter int HOLDOFF    = 8191,
    parameter int MSB_FIRST  = 1,
    parameter int CONTINUOUS = 1
) (
    input  logic                        sys_clk_i,
    input  logic                        sys_rst_i,
    input  logic                        start_i,
    output logic [$clog2(COLS)-1:0]     rd_x_o,
    output logic [$clog2(ROWS)-1:0]     rd_y_o,
    input  logic [8*WORD_BYTES-1:0]     rd_data_i,
    input  logic                        uart_busy_i,
    output logic                        uart_wr_o,
    output logic [7:0]                  uart_dat_o,
    output logic                        busy_o,
    output logic                        frame_done_o
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam int DW = 8 * WORD_BYTES;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

`ifdef FRAME_HDR_EN
    typedef enum logic [2:0] {IDLE, HDR, FETCH, LATCH, SEND, NEXT} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, NEXT} state_t;
`endif

    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic [IW-1:0]   byte_idx;
    logic [DW-1:0]   word_sr;
    logic            wr_ok, wr_go, frame_end, x_last, y_last;
    logic [7:0]      tx_byte;
`ifdef FRAME_HDR_EN
    logic [1:0]      hdr_idx;
    logic [7:0]      frame_cnt;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [7:0] cnt);
        case (idx)
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = 8'h5A;
            2'd2:    hdr_byte = cnt;
            default: hdr_byte = ~cnt;
        endcase
    endfunction
`endif

    function automatic logic [7:0] head_byte(input logic [DW-1:0] w);
        head_byte = (MSB_FIRST != 0) ? w[DW-1 -: 8] : w[7:0];
    endfunction

    // uart_wr_o in the gate keeps strobes from ever landing back to back
    assign wr_ok  = (hold_cnt == HW'(HOLDOFF)) && !uart_busy_i && !uart_wr_o;
    assign x_last = (rd_x_o == XW'(COLS - 1));
    assign y_last = (rd_y_o == YW'(ROWS - 1));
    assign busy_o = (state != IDLE);

    always_comb begin
        state_nxt = state;
        wr_go     = 1'b0;
        frame_end = 1'b0;
        tx_byte   = head_byte(word_sr);
        case (state)
`ifdef FRAME_HDR_EN
            IDLE:  if (CONTINUOUS != 0 || start_i) state_nxt = HDR;
            HDR: begin
                tx_byte = hdr_byte(hdr_idx, frame_cnt);
                if (wr_ok) begin
                    wr_go = 1'b1;
                    if (hdr_idx == 2'd3) state_nxt = FETCH;
                end
            end
`else
            IDLE:  if (CONTINUOUS != 0 || start_i) state_nxt = FETCH;
`endif
            FETCH: state_nxt = LATCH;
            LATCH: state_nxt = SEND;
            SEND: begin
                if (wr_ok) begin
                    wr_go = 1'b1;
                    if (byte_idx == IW'(WORD_BYTES - 1)) state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (x_last && y_last) begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state        <= IDLE;
            rd_x_o       <= '0;
            rd_y_o       <= '0;
            hold_cnt     <= '0;
            byte_idx     <= '0;
            uart_wr_o    <= 1'b0;
            uart_dat_o   <= 8'h00;
            frame_done_o <= 1'b0;
`ifdef FRAME_HDR_EN
            hdr_idx      <= 2'd0;
            frame_cnt    <= 8'h00;
`endif
        end else begin
            state        <= state_nxt;
            uart_wr_o    <= wr_go;
            frame_done_o <= frame_end;
            if (wr_go) uart_dat_o <= tx_byte;

            // holdoff counts clean line cycles, saturating so a long idle still permits an immediate write
            if (uart_busy_i || uart_wr_o)
                hold_cnt <= '0;
            else if (hold_cnt != HW'(HOLDOFF))
                hold_cnt <= hold_cnt + 1'b1;

            if (state == LATCH)
                byte_idx <= '0;
            else if (state == SEND && wr_go)
                byte_idx <= byte_idx + 1'b1;

`ifdef FRAME_HDR_EN
            if (state == IDLE)
                hdr_idx <= 2'd0;
            else if (state == HDR && wr_go)
                hdr_idx <= hdr_idx + 1'b1;
            if (frame_end) frame_cnt <= frame_cnt + 1'b1;
`endif

            if (state == IDLE) begin
                rd_x_o <= '0;
                rd_y_o <= '0;
            end else if (state == NEXT) begin
                if (!x_last) begin
                    rd_x_o <= rd_x_o + 1'b1;
                end else begin
                    rd_x_o <= '0;
                    rd_y_o <= y_last ? '0 : rd_y_o + 1'b1;
                end
            end
        end
    end

    // word shift register: loaded one cycle after FETCH so the buffer's read latency is absorbed
    always_ff @(posedge sys_clk_i) begin
        if (state == LATCH)
            word_sr <= rd_data_i;
        else if (state == SEND && wr_go)
            word_sr <= (MSB_FIRST != 0) ? (word_sr << 8) : (word_sr >> 8);
    end

endmodule

// File: tb/tb_frame_dump_seq.sv
// Randomised bench for frame_dump_seq: unit 0 is triggered MSB-first with a busy-asserting UART,
// unit 1 is free-running LSB-first on an always-idle UART; both compared against a byte-queue model.
module tb_frame_dump_seq;

    localparam int COLS = 3;
    localparam int ROWS = 2;
    localparam int WB   = 2;
    localparam int HOLD = 3;
`ifdef FRAME_HDR_EN
    localparam int HDR_N = 4;
`else
    localparam int HDR_N = 0;
`endif
    localparam int FRAME_BYTES = HDR_N + COLS * ROWS * WB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy_a = 1'b0;
    logic [1:0]  rd_x [2];
    logic [0:0]  rd_y [2];
    logic [15:0] rd_data [2];
    logic [15:0] pend [2];
    logic        wr [2];
    logic [7:0]  dat [2];
    logic        bsy [2];
    logic        fd [2];
    logic [15:0] mem [2][ROWS][COLS];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q [2][$];
    int  fc [2];
    int  fbytes [2];
    int  frames [2];
    int  idle_run [2];
    bit  first_wr [2];
    bit  prev_wr [2];
    bit  prev_fd [2];
    int  busy_mode = 0;
    int  busy_n;

    always #5 clk = ~clk;

    frame_dump_seq #(.COLS(COLS), .ROWS(ROWS), .WORD_BYTES(WB), .HOLDOFF(HOLD),
                     .MSB_FIRST(1), .CONTINUOUS(0)) dut_a (
        .sys_clk_i(clk), .sys_rst_i(rst), .start_i(start),
        .rd_x_o(rd_x[0]), .rd_y_o(rd_y[0]), .rd_data_i(rd_data[0]),
        .uart_busy_i(busy_a), .uart_wr_o(wr[0]), .uart_dat_o(dat[0]),
        .busy_o(bsy[0]), .frame_done_o(fd[0]));

    frame_dump_seq #(.COLS(COLS), .ROWS(ROWS), .WORD_BYTES(WB), .HOLDOFF(HOLD),
                     .MSB_FIRST(0), .CONTINUOUS(1)) dut_b (
        .sys_clk_i(clk), .sys_rst_i(rst), .start_i(1'b0),
        .rd_x_o(rd_x[1]), .rd_y_o(rd_y[1]), .rd_data_i(rd_data[1]),
        .uart_busy_i(1'b0), .uart_wr_o(wr[1]), .uart_dat_o(dat[1]),
        .busy_o(bsy[1]), .frame_done_o(fd[1]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int u);
        logic [15:0] w;
`ifdef FRAME_HDR_EN
        exp_q[u].push_back(8'hA5);
        exp_q[u].push_back(8'h5A);
        exp_q[u].push_back(8'(fc[u]));
        exp_q[u].push_back(8'(~fc[u]));
`endif
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                w = mem[u][y][x];
                if (u == 0) begin
                    exp_q[u].push_back(w[15:8]);
                    exp_q[u].push_back(w[7:0]);
                end else begin
                    exp_q[u].push_back(w[7:0]);
                    exp_q[u].push_back(w[15:8]);
                end
            end
    endtask

    task automatic reset_models();
        for (int u = 0; u < 2; u++) begin
            exp_q[u].delete();
            fc[u] = 0;
            fbytes[u] = 0;
            first_wr[u] = 1'b1;
        end
    endtask

    task automatic randomize_mem();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                mem[0][y][x] = 16'($urandom);
    endtask

    task automatic start_frame();
        push_frame(0);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic run_frame(input bit mid_start);
        int f0;
        int k;
        f0 = frames[0];
        start_frame();
        for (k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            if (mid_start && k == 20) start = 1'b1;
            if (mid_start && k == 21) start = 1'b0;
            if (frames[0] > f0) break;
        end
        start = 1'b0;
        check_val("a_frame_completes", k < 3000, 1);
    endtask

    // synchronous-read buffer: data appears one cycle after the address
    initial begin
        pend[0] = '0; pend[1] = '0;
        rd_data[0] = '0; rd_data[1] = '0;
        forever begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                rd_data[u] = pend[u];
                pend[u] = mem[u][rd_y[u]][rd_x[u]];
            end
        end
    end

    // UART for unit 0: after each strobe, busy for 0 (mode 0), 10 (mode 1) or random 0..10 (mode 2) cycles
    initial begin
        forever begin
            @(posedge clk); #1;
            if (wr[0] && busy_mode != 0) begin
                busy_n = (busy_mode == 1) ? 10 : int'($urandom_range(0, 10));
                if (busy_n > 0) begin
                    @(posedge clk); #1 busy_a = 1'b1;
                    repeat (busy_n) @(posedge clk);
                    #1 busy_a = 1'b0;
                end
            end
        end
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            frames[u] = 0; idle_run[u] = 0; prev_wr[u] = 0; prev_fd[u] = 0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rst) begin
                    idle_run[u] = 0;
                    prev_wr[u] = 0;
                    prev_fd[u] = 0;
                end else begin
                    if (wr[u]) begin
                        if (exp_q[u].size() == 0)
                            check_val($sformatf("u%0d_unexpected_wr", u), 1, 0);
                        else
                            check_val($sformatf("u%0d_byte%0d", u, fbytes[u]), dat[u], exp_q[u].pop_front());
                        if (first_wr[u])
                            check_val($sformatf("u%0d_gap_min", u), idle_run[u] >= HOLD + 1, 1);
                        else
                            check_val($sformatf("u%0d_gap", u), idle_run[u], HOLD + 1);
                        first_wr[u] = 1'b0;
                        fbytes[u]++;
                    end
                    if (fd[u]) begin
                        check_val($sformatf("u%0d_done_after_wr", u), prev_wr[u], 1);
                        check_val($sformatf("u%0d_frame_bytes", u), fbytes[u], FRAME_BYTES);
                        check_val($sformatf("u%0d_idle_at_done", u), bsy[u], 0);
                        frames[u]++;
                        fc[u] = (fc[u] + 1) % 256;
                        fbytes[u] = 0;
                        first_wr[u] = 1'b1;
                        if (u == 1) push_frame(1);
                    end
                    if (u == 1 && prev_fd[u])
                        check_val("b_restart_after_one_idle", bsy[1], 1);
                    if (wr[u] || (u == 0 && busy_a))
                        idle_run[u] = 0;
                    else if (idle_run[u] < 1000)
                        idle_run[u]++;
                    prev_wr[u] = wr[u];
                    prev_fd[u] = fd[u];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int fb0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                mem[0][y][x] = '0;
                mem[1][y][x] = 16'($urandom);
            end
        mem[1][0][0] = 16'hBEEF;

        repeat (3) @(posedge clk);
        #2;
        check_val("rst_wr", wr[0], 0);
        check_val("rst_dat", dat[0], 0);
        check_val("rst_busy", bsy[0], 0);
        check_val("rst_done", fd[0], 0);
        check_val("rst_x", rd_x[0], 0);
        check_val("rst_y", rd_y[0], 0);
        check_val("rst_busy_b", bsy[1], 0);
        reset_models();
        push_frame(1);
        rst = 1'b0;

        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                mem[0][y][x] = {8'(y), 8'(x)};
        busy_mode = 0;
        run_frame(1'b0);

        busy_mode = 1;
        randomize_mem();
        run_frame(1'b0);

        busy_mode = 2;
        randomize_mem();
        run_frame(1'b1);
        repeat (20) @(posedge clk);
        #2 check_val("a_idle_after_frame", bsy[0], 0);

        busy_mode = 0;
        repeat (12) @(posedge clk);
        randomize_mem();
        start_frame();
        for (k = 0; k < 2000; k++) begin
            @(posedge clk); #2;
            if (wr[0] && fbytes[0] == HDR_N + 9) break;
        end
        check_val("rst_target_found", k < 2000, 1);
        check_val("pre_rst_x", rd_x[0], 1);
        check_val("pre_rst_y", rd_y[0], 1);
        rst = 1'b1;
        #1;
        check_val("midrst_wr", wr[0], 0);
        check_val("midrst_busy", bsy[0], 0);
        check_val("midrst_x", rd_x[0], 0);
        check_val("midrst_y", rd_y[0], 0);
        repeat (2) @(posedge clk);
        #2;
        reset_models();
        push_frame(1);
        fb0 = frames[1];
        rst = 1'b0;

        run_frame(1'b0);

        for (k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            if (frames[1] >= fb0 + 2) break;
        end
        check_val("b_two_frames_after_rst", frames[1] >= fb0 + 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
